// File: rtl/pcpi_initiator.sv
// pcpi_initiator
//   Takes one command at a time from a valid/ready command port and presents
//   it to a PicoRV32-style PCPI coprocessor. It captures the coprocessor
//   result and returns it on a valid/ready response port.
//
//   Optional feature: define PCPI_INITIATOR_TIMEOUT_EN to abandon an issued
//   instruction after TIMEOUT_CYCLES cycles in which pcpi_wait and pcpi_ready
//   are both low. An abandoned instruction produces a response with
//   rsp_timeout=1. When the macro is undefined, ISSUE waits indefinitely and
//   rsp_timeout is tied low.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_insn/cmd_rs1/cmd_rs2    instruction and operands
//   rsp_valid/rsp_ready         response handshake
//   rsp_wr/rsp_rd/rsp_timeout   captured result and timeout flag
//   pcpi_valid/insn/rs1/rs2     coprocessor request (registered)
//   pcpi_wr/rd/wait/ready       coprocessor reply
module pcpi_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [31:0] rsp_rd,
  output logic        rsp_timeout,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("pcpi_initiator: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic        wr_q, wr_d;
  logic [31:0] rd_q, rd_d;

`ifdef PCPI_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
`else
  logic       unused_wait;
  assign unused_wait = pcpi_wait;
`endif

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = ISSUE;
          insn_d  = cmd_insn;
          rs1_d   = cmd_rs1;
          rs2_d   = cmd_rs2;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
          cnt_d   = TO_LOAD;
`endif
        end
      end
      ISSUE: begin
        // pcpi_ready is checked first so it beats an expiring counter
        if (pcpi_ready) begin
          state_d = RESP;
          wr_d    = pcpi_wr;
          rd_d    = pcpi_rd;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
`ifdef PCPI_INITIATOR_TIMEOUT_EN
        else if (pcpi_wait) begin
          cnt_d = TO_LOAD;
        end else if (cnt_q == 8'd0) begin
          state_d = RESP;
          wr_d    = 1'b0;
          rd_d    = 32'd0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign pcpi_valid = (state_q == ISSUE);
  assign rsp_valid  = (state_q == RESP);
  assign pcpi_insn  = insn_q;
  assign pcpi_rs1   = rs1_q;
  assign pcpi_rs2   = rs2_q;
  assign rsp_wr     = wr_q;
  assign rsp_rd     = rd_q;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
  assign rsp_timeout = to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pcpi_initiator.sv
module tb_pcpi_initiator;
  localparam int T = 16;
`ifdef PCPI_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
  logic        rsp_valid, rsp_ready, rsp_wr, rsp_timeout;
  logic [31:0] rsp_rd;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;

  always #5 clk = ~clk;

  pcpi_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_timeout(rsp_timeout),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );

  int vecs = 0;
  int errs = 0;

  // responder schedule, one entry per ISSUE cycle: {wait, ready}, wr, rd
  bit [1:0]    act[$];
  bit          wrq[$];
  logic [31:0] rdq[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit w, input bit r, input bit wr, input logic [31:0] rd);
    act.push_back({w, r});
    wrq.push_back(wr);
    rdq.push_back(rd);
  endtask

  // n cycles, each waiting with probability 1/wdiv, then one ready cycle
  task automatic rand_sched(input int n, input int wdiv);
    for (int i = 0; i < n; i++)
      push(($urandom % wdiv) == 0, 1'b0, 1'($urandom), $urandom);
    push(1'b0, 1'b1, 1'($urandom), $urandom);
  endtask

  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input int hold, input bit b2b);
    int run, exp_len, len;
    bit exp_to, exp_wr;
    logic [31:0] exp_rd;
    // Reference: the result is the first ready cycle, unless T consecutive
    // cycles with neither wait nor ready come first (timeout build only).
    run = 0; exp_len = 0; exp_to = 0; exp_wr = 0; exp_rd = 0;
    for (int i = 0; i < act.size(); i++) begin
      if (act[i][0]) begin
        exp_len = i + 1; exp_wr = wrq[i]; exp_rd = rdq[i];
        break;
      end
      run = act[i][1] ? 0 : run + 1;
      if (TO_EN && run == T) begin
        exp_len = i + 1; exp_to = 1'b1;
        break;
      end
    end

    chk("idle_ready", {cmd_ready, pcpi_valid, rsp_valid}, 3'b100);
    cmd_valid = 1'b1; cmd_insn = insn; cmd_rs1 = rs1; cmd_rs2 = rs2;
    tick();
    cmd_valid = 1'b0; cmd_insn = $urandom; cmd_rs1 = $urandom; cmd_rs2 = $urandom;

    len = 0;
    while (pcpi_valid === 1'b1 && len < 600) begin
      chk("pcpi_ops", {pcpi_insn, pcpi_rs1, pcpi_rs2}, {insn, rs1, rs2});
      if (len < act.size()) begin
        {pcpi_wait, pcpi_ready} = act[len];
        pcpi_wr = wrq[len]; pcpi_rd = rdq[len];
      end else begin
        pcpi_wait = 1'b0; pcpi_ready = 1'b0;
      end
      tick();
      len++;
    end
    pcpi_wait = 1'b0; pcpi_ready = 1'b0;
    chk("issue_len", len, exp_len);

    for (int h = 0; h <= hold; h++) begin
      chk("rsp", {rsp_valid, rsp_timeout, rsp_wr, rsp_rd}, {1'b1, exp_to, exp_wr, exp_rd});
      chk("resp_ctl", {cmd_ready, pcpi_valid, pcpi_insn}, {2'b00, insn});
      if (h < hold) begin
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_insn = $urandom;
        pcpi_ready = 1'($urandom); pcpi_wr = 1'($urandom); pcpi_rd = $urandom;
      end else begin
        rsp_ready = 1'b1; cmd_valid = b2b; pcpi_ready = 1'b0;
      end
      tick();
    end
    rsp_ready = 1'b0;
    // command held across the consume edge is not taken on that edge
    chk("post_consume", {cmd_ready, rsp_valid, pcpi_valid}, 3'b100);
    cmd_valid = 1'b0;
    act.delete(); wrq.delete(); rdq.delete();
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 0; cmd_insn = 0; cmd_rs1 = 0; cmd_rs2 = 0; rsp_ready = 0;
    pcpi_wr = 0; pcpi_rd = 0; pcpi_wait = 0; pcpi_ready = 0;
    tick(); tick();
    chk("reset_ctl", {pcpi_valid, rsp_valid, rsp_wr, rsp_timeout, rsp_rd}, 36'd0);
    chk("reset_ops", {pcpi_insn, pcpi_rs1, pcpi_rs2}, 96'd0);
    reset = 1'b0;
    tick();
    chk("reset_cmd_ready", cmd_ready, 1'b1);

    // one idle cycle, then wait x3, then ready
    push(0, 0, 0, 32'h1111_1111);
    for (int i = 0; i < 3; i++) push(1, 0, 0, 32'h2222_2222);
    push(0, 1, 1, 32'h4040_0000);
    run_txn(32'h0020_0053, 32'h3F80_0000, 32'h4000_0000, 0, 0);

    // silent responder; ready arrives late at index 40
    for (int i = 0; i < 40; i++) push(0, 0, 1, $urandom);
    push(0, 1, 1, 32'hDEAD_BEEF);
    run_txn($urandom, $urandom, $urandom, 2, 0);

    // 40 wait cycles then ready: never a timeout
    for (int i = 0; i < 40; i++) push(1, 0, 1, $urandom);
    push(0, 1, 1, 32'h1234_5678);
    run_txn($urandom, $urandom, $urandom, 1, 0);

    // ready on the cycle the counter hits zero wins
    for (int i = 0; i < T - 1; i++) push(0, 0, 0, $urandom);
    push(0, 1, 0, 32'hCAFE_F00D);
    run_txn($urandom, $urandom, $urandom, 0, 1);

    // response back-pressured 10 cycles, then back-to-back command
    rand_sched(4, 2);
    run_txn($urandom, $urandom, $urandom, 10, 1);
    rand_sched(2, 2);
    run_txn($urandom, $urandom, $urandom, 0, 0);

    // responder silent 300 cycles
    for (int i = 0; i < 300; i++) push(0, 0, 0, $urandom);
    push(0, 1, 1, 32'h0BAD_F00D);
    run_txn($urandom, $urandom, $urandom, 0, 0);

    // randomized transactions, sparse waits make timeouts likely
    for (int n = 0; n < 24; n++) begin
      rand_sched($urandom_range(0, 30), (n % 2) ? 2 : 10);
      run_txn($urandom, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    // reset two cycles into ISSUE, then a stray pcpi_ready
    cmd_valid = 1'b1; cmd_insn = 32'hA5A5_0001; cmd_rs1 = 32'h1; cmd_rs2 = 32'h2;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("pre_reset_issue", pcpi_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk("midreset_ctl", {pcpi_valid, rsp_valid, rsp_wr, rsp_timeout, rsp_rd}, 36'd0);
    chk("midreset_ops", {pcpi_insn, pcpi_rs1, pcpi_rs2}, 96'd0);
    reset = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hFFFF_FFFF;
    tick();
    pcpi_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_ready", {cmd_ready, rsp_valid, pcpi_valid, rsp_wr, rsp_rd}, {3'b100, 33'd0});
      tick();
    end

    // still fully functional after the mid-transaction reset
    rand_sched(3, 2);
    run_txn($urandom, $urandom, $urandom, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
